vliw_issue_ctrl: RTL and testbench

Issue controller placed in front of `vliw_top`. It accepts 3-slot VLIW bundles (64-bit instruction word plus 192-bit immediate data) from the fetch side over a valid/ready handshake. A 16-entry register scoreboard detects read-after-write hazards against in-flight results and holds a dependent bundle until its operands are ready, inserting NOP bundles meanwhile. It drives `vliw_top`'s `word`/`data` inputs and flushes on the core's `jump` output.

---
 rtl/vliw_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_vliw_issue_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vliw_issue_ctrl.sv
// vliw_issue_ctrl: one-entry hold register, 16-register scoreboard and
// jump flush sitting in front of vliw_top.
module vliw_issue_ctrl #(
  parameter int unsigned WB_LAT    = 3,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         bundle_valid,
  input  logic [63:0]  bundle_word,
  input  logic [191:0] bundle_data,
  output logic         bundle_ready,
  input  logic         jump,
  output logic [63:0]  issue_word,
  output logic [191:0] issue_data,
  output logic         stall,
  output logic [15:0]  stall_cnt
);

  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpSub  = 4'd2;
  localparam logic [3:0] OpMul  = 4'd3;
  localparam logic [3:0] OpLoad = 4'd4;
  localparam logic [3:0] OpRead = 4'd6;

  localparam logic [18:0] SlotMask = 19'b1111_0_1111_0_1111_0_1111;
  localparam logic [63:0] WordMask =
    {5'b0, SlotMask, 1'b0, SlotMask, 1'b0, SlotMask};
  localparam logic [2:0] LatV   = 3'(WB_LAT);
  localparam logic [2:0] FlushV = 3'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_FLUSH
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     fcnt_q, fcnt_d;
  logic [63:0]    hold_word_q, hold_word_d;
  logic [191:0]   hold_data_q, hold_data_d;
  logic [63:0]    iw_q, iw_d;
  logic [191:0]   id_q, id_d;
  logic [15:0]    scnt_q, scnt_d;
  logic [2:0]     busy_q [16];
  logic [2:0]     busy_d [16];

  logic [15:0]    rd_mask;
  logic [15:0]    wr_mask;
  logic [2:0]     use_v;
  logic           hazard;
  logic           issue;
  logic           stall_int;
  logic           accept;

  // {reads src1, reads src2, writes dest}
  function automatic logic [2:0] use_of(input logic [3:0] op);
    logic alu, ld, rd;
    alu = (op == OpAdd) || (op == OpSub) || (op == OpMul);
    ld  = (op == OpLoad);
    rd  = (op == OpRead);
    use_of = 3'b000;
    unique case (1'b1)
      alu:     use_of = 3'b111;
      ld:      use_of = 3'b001;
      rd:      use_of = 3'b100;
      default: use_of = 3'b000;
    endcase
  endfunction

  always_comb begin
    rd_mask = '0;
    wr_mask = '0;
    use_v   = '0;
    for (int s = 0; s < 3; s++) begin
      use_v = use_of(hold_word_q[s*20+15 +: 4]);
      if (use_v[2]) rd_mask[hold_word_q[s*20+10 +: 4]] = 1'b1;
      if (use_v[1]) rd_mask[hold_word_q[s*20+5 +: 4]]  = 1'b1;
      if (use_v[0]) wr_mask[hold_word_q[s*20 +: 4]]    = 1'b1;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int r = 0; r < 16; r++) begin
      if (rd_mask[r] && (busy_q[r] > 3'd1)) hazard = 1'b1;
    end
  end

  assign issue     = (state_q == S_HOLD) && !jump && !hazard;
  assign stall_int = (state_q == S_HOLD) && !jump && hazard;
  assign bundle_ready = reset && !jump &&
                        ((state_q == S_IDLE) || issue);
  assign accept    = bundle_valid && bundle_ready;
  assign stall     = reset && stall_int;

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    hold_word_d = hold_word_q;
    hold_data_d = hold_data_q;
    iw_d        = '0;
    id_d        = '0;
    scnt_d      = scnt_q;
    for (int r = 0; r < 16; r++) begin
      busy_d[r] = (busy_q[r] != 3'd0) ? busy_q[r] - 3'd1 : 3'd0;
    end
    if (issue) begin
      iw_d = hold_word_q & WordMask;
      id_d = hold_data_q;
      for (int r = 0; r < 16; r++) begin
        if (wr_mask[r]) busy_d[r] = LatV;
      end
    end
    if (stall_int && (scnt_q != 16'hFFFF)) scnt_d = scnt_q + 16'd1;
    if (accept) begin
      hold_word_d = bundle_word;
      hold_data_d = bundle_data;
    end
    // The jump cycle itself is the first of the FLUSH_CYC dead cycles.
    if (jump) begin
      fcnt_d  = FlushV;
      state_d = (FlushV == 3'd0) ? S_IDLE : S_FLUSH;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = S_HOLD;
        S_HOLD:  if (issue && !accept) state_d = S_IDLE;
        S_FLUSH: begin
          if (fcnt_q <= 3'd1) state_d = S_IDLE;
          else fcnt_d = fcnt_q - 3'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      fcnt_q      <= '0;
      hold_word_q <= '0;
      hold_data_q <= '0;
      iw_q        <= '0;
      id_q        <= '0;
      scnt_q      <= '0;
      busy_q      <= '{default: 3'd0};
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      hold_word_q <= hold_word_d;
      hold_data_q <= hold_data_d;
      iw_q        <= iw_d;
      id_q        <= id_d;
      scnt_q      <= scnt_d;
      busy_q      <= busy_d;
    end
  end

  assign issue_word = iw_q;
  assign issue_data = id_q;
  assign stall_cnt  = scnt_q;

endmodule

// File: tb/tb_vliw_issue_ctrl.sv
// tb_vliw_issue_ctrl: directed vector table plus reset, flush and
// stall-counter saturation sequences.
module tb_vliw_issue_ctrl;

  localparam logic [3:0] NOP = 4'd0;
  localparam logic [3:0] ADD = 4'd1;
  localparam logic [3:0] SUB = 4'd2;
  localparam logic [3:0] MUL = 4'd3;
  localparam logic [3:0] LD  = 4'd4;
  localparam logic [3:0] RD  = 4'd6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, bv, br, jmp, stl;
  logic [63:0]  bw_i, iw;
  logic [191:0] bd_i, id;
  logic [15:0]  cnt;

  logic         r7, v7, rdy7, j7, st7;
  logic [63:0]  w7, iw7;
  logic [191:0] d7, id7;
  logic [15:0]  cnt7;

  vliw_issue_ctrl #(.WB_LAT(3), .FLUSH_CYC(2)) dut (
    .clock(clock), .reset(reset), .bundle_valid(bv),
    .bundle_word(bw_i), .bundle_data(bd_i), .bundle_ready(br),
    .jump(jmp), .issue_word(iw), .issue_data(id),
    .stall(stl), .stall_cnt(cnt)
  );

  vliw_issue_ctrl #(.WB_LAT(7), .FLUSH_CYC(2)) dut7 (
    .clock(clock), .reset(r7), .bundle_valid(v7),
    .bundle_word(w7), .bundle_data(d7), .bundle_ready(rdy7),
    .jump(j7), .issue_word(iw7), .issue_data(id7),
    .stall(st7), .stall_cnt(cnt7)
  );

  typedef struct {
    logic         v;
    logic [63:0]  w;
    logic [191:0] d;
    logic         j;
    logic         rdy;
    logic         stl;
    logic [63:0]  iw;
    logic [191:0] id;
    logic [15:0]  cnt;
  } vec_t;

  vec_t tv[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [18:0] slot(input logic [3:0] op, s1, s2, d);
    return {op, 1'b0, s1, 1'b0, s2, 1'b0, d};
  endfunction

  function automatic logic [63:0] bw(input logic [18:0] a, b, c);
    return {5'b0, a, 1'b0, b, 1'b0, c};
  endfunction

  function automatic vec_t mk(input logic v, input logic [63:0] w,
                              input logic [191:0] d, input logic j,
                              input logic rdy, input logic s,
                              input logic [63:0] ew,
                              input logic [191:0] ed,
                              input logic [15:0] ec);
    vec_t t;
    t.v = v; t.w = w; t.d = d; t.j = j; t.rdy = rdy; t.stl = s;
    t.iw = ew; t.id = ed; t.cnt = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    logic [18:0]  z;
    logic [63:0]  w1, w2, w3, l4, a, ld3, rr, ld12, rx;
    logic [63:0]  rsvc, rsvw, rsv, c5, j1, nn, ld9, ad9;
    logic [191:0] d1, d2, d3, dl, da, db, dr, dc, dx, ds, dc5;
    logic [191:0] dj, dn, d9, da9;
    int n, cyc;
    bit c1, c2;

    z    = '0;
    w1   = bw(slot(LD,0,0,0), slot(LD,0,0,1), slot(LD,0,0,2));
    w2   = bw(slot(LD,0,0,3), slot(LD,0,0,4), slot(LD,0,0,5));
    w3   = bw(slot(LD,0,0,6), slot(LD,0,0,7), slot(LD,0,0,8));
    l4   = bw(slot(NOP,0,0,0), slot(LD,0,0,4), slot(NOP,0,0,0));
    a    = bw(slot(ADD,4,5,10), z, z);
    ld3  = bw(slot(LD,0,0,3), slot(LD,0,0,0), z);
    rr   = bw(slot(RD,3,0,0), z, z);
    ld12 = bw(slot(LD,0,0,12), z, z);
    rx   = bw(slot(RD,0,12,0), z, z);
    rsvc = bw(slot(MUL,1,2,5), slot(SUB,5,5,5), slot(ADD,5,6,5));
    rsv  = ~bw(slot(4'hF,4'hF,4'hF,4'hF), slot(4'hF,4'hF,4'hF,4'hF),
               slot(4'hF,4'hF,4'hF,4'hF));
    rsvw = rsvc | rsv;
    c5   = bw(slot(ADD,5,0,7), z, z);
    j1   = bw(slot(ADD,7,7,8), z, z);
    nn   = bw(slot(SUB,8,8,3), z, z);
    ld9  = bw(z, z, slot(LD,0,0,9));
    ad9  = bw(slot(ADD,9,9,11), z, z);

    d1  = {64'h123456789abcdef0, 64'h0fedcba987654321, 64'hdeadbeefcafef00d};
    d2  = {64'h0123456789abcdef, 64'h1, 64'h2};
    d3  = {64'h3, 64'h4, 64'h5};
    dl  = {64'h44, 64'h4400, 64'h440000};
    da  = {3{64'haaaa5555aaaa5555}};
    db  = {64'hb0, 64'hb1, 64'hb2};
    dr  = {3{64'h0123456700000003}};
    dc  = {64'hc12, 64'h0, 64'hc12};
    dx  = {3{64'hffff0000ffff0000}};
    ds  = {3{64'h5a5a5a5a5a5a5a5a}};
    dc5 = {64'hc5, 64'hc5c5, 64'hc5c5c5};
    dj  = {3{64'hdeaddeaddeaddead}};
    dn  = {64'h0e0e, 64'h0f0f, 64'h1010};
    d9  = {64'h9, 64'h99, 64'h999};
    da9 = {64'ha9, 64'ha99, 64'ha999};

    //          v  word  data j rdy stl  iw    id   cnt
    tv.push_back(mk(1, w1,  d1,  0, 1, 0, 0,    0,   0));
    tv.push_back(mk(1, w2,  d2,  0, 1, 0, 0,    0,   0));
    tv.push_back(mk(1, w3,  d3,  0, 1, 0, w1,   d1,  0));
    tv.push_back(mk(0, 0,   0,   0, 1, 0, w2,   d2,  0));
    tv.push_back(mk(0, 0,   0,   0, 1, 0, w3,   d3,  0));
    tv.push_back(mk(0, 0,   0,   0, 1, 0, 0,    0,   0));
    tv.push_back(mk(0, 0,   0,   0, 1, 0, 0,    0,   0));
    tv.push_back(mk(1, l4,  dl,  0, 1, 0, 0,    0,   0));
    tv.push_back(mk(1, a,   da,  0, 1, 0, 0,    0,   0));
    tv.push_back(mk(0, 0,   0,   0, 0, 1, l4,   dl,  0));
    tv.push_back(mk(0, 0,   0,   0, 0, 1, 0,    0,   1));
    tv.push_back(mk(0, 0,   0,   0, 1, 0, 0,    0,   2));
    tv.push_back(mk(1, ld3, db,  0, 1, 0, a,    da,  2));
    tv.push_back(mk(1, rr,  dr,  0, 1, 0, 0,    0,   2));
    tv.push_back(mk(0, 0,   0,   0, 0, 1, ld3,  db,  2));
    tv.push_back(mk(0, 0,   0,   0, 0, 1, 0,    0,   3));
    tv.push_back(mk(0, 0,   0,   0, 1, 0, 0,    0,   4));
    tv.push_back(mk(1, ld12, dc, 0, 1, 0, rr,   dr,  4));
    tv.push_back(mk(1, rx,  dx,  0, 1, 0, 0,    0,   4));
    tv.push_back(mk(0, 0,   0,   0, 1, 0, ld12, dc,  4));
    tv.push_back(mk(1, rsvw, ds, 0, 1, 0, rx,   dx,  4));
    tv.push_back(mk(0, 0,   0,   0, 1, 0, 0,    0,   4));
    tv.push_back(mk(1, c5,  dc5, 0, 1, 0, rsvc, ds,  4));
    tv.push_back(mk(0, 0,   0,   0, 0, 1, 0,    0,   4));
    tv.push_back(mk(0, 0,   0,   0, 1, 0, 0,    0,   5));
    tv.push_back(mk(1, j1,  dj,  0, 1, 0, c5,   dc5, 5));
    tv.push_back(mk(1, nn,  dn,  1, 0, 0, 0,    0,   5));
    tv.push_back(mk(1, nn,  dn,  0, 0, 0, 0,    0,   5));
    tv.push_back(mk(1, nn,  dn,  0, 1, 0, 0,    0,   5));
    tv.push_back(mk(0, 0,   0,   0, 1, 0, 0,    0,   5));
    tv.push_back(mk(1, ld9, d9,  0, 1, 0, nn,   dn,  5));
    tv.push_back(mk(1, ad9, da9, 0, 1, 0, 0,    0,   5));
    tv.push_back(mk(1, ad9, da9, 0, 0, 1, ld9,  d9,  5));

    reset = 1'b0; bv = 1'b0; bw_i = '0; bd_i = '0; jmp = 1'b0;
    r7 = 1'b0; v7 = 1'b0; w7 = '0; d7 = '0; j7 = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_word", 0, iw, 64'd0);
    chk("rst_data", 0, id, 192'd0);
    chk("rst_cnt", 0, cnt, 16'd0);
    chk("rst_ready", 0, br, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clock);
      bv = tv[i].v; bw_i = tv[i].w; bd_i = tv[i].d; jmp = tv[i].j;
      #1;
      chk("ready", i, br, tv[i].rdy);
      chk("stall", i, stl, tv[i].stl);
      chk("iword", i, iw, tv[i].iw);
      chk("idata", i, id, tv[i].id);
      chk("scnt", i, cnt, tv[i].cnt);
    end

    // Reset mid-stall with the dependent add still held.
    reset = 1'b0;
    #1;
    chk("mr_word", 0, iw, 64'd0);
    chk("mr_data", 0, id, 192'd0);
    chk("mr_cnt", 0, cnt, 16'd0);
    chk("mr_ready", 0, br, 1'b0);
    chk("mr_stall", 0, stl, 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk("mr_hold", 0, br, 1'b0);
    reset = 1'b1;
    #1;
    chk("rel_ready", 0, br, 1'b1);
    @(negedge clock);
    bv = 1'b0; bw_i = '0; bd_i = '0;
    #1;
    chk("rel_stall", 0, stl, 1'b0);
    chk("rel_ready", 1, br, 1'b1);
    @(negedge clock);
    #1;
    chk("rel_word", 0, iw, ad9);
    chk("rel_data", 0, id, da9);
    chk("rel_cnt", 0, cnt, 16'd0);

    // Saturation: a self-dependent add chain with WB_LAT=7.
    @(negedge clock);
    r7 = 1'b1; v7 = 1'b1; w7 = bw(slot(ADD,1,1,1), z, z);
    d7 = {3{64'h7777}};
    n = 0; cyc = 0; c1 = 1'b0; c2 = 1'b0;
    while (n < 65540 && cyc < 80000) begin
      @(negedge clock);
      #1;
      cyc++;
      if (n == 65534 && !c1) begin
        chk("sat_pre", n, cnt7, 16'hFFFE);
        c1 = 1'b1;
      end
      if (n == 65535 && !c2) begin
        chk("sat_max", n, cnt7, 16'hFFFF);
        c2 = 1'b1;
      end
      if (st7) n++;
    end
    chk("sat_budget", cyc, n, 65540);
    @(negedge clock);
    #1;
    chk("sat_hold", n, cnt7, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
